// File: rtl/mac_if_pkg.sv
// mac_if_pkg: shared widths, pipe word field positions and receive FSM encoding.
package mac_if_pkg;
  localparam int N        = 32;
  localparam int S        = N / 8;
  localparam int D        = N + S + 1;
  localparam int DEPTH    = 128;
  localparam int D_S      = 7;
  localparam int DATA_LSB = 0;
  localparam int KEEP_LSB = N;
  localparam int LAST_BIT = N + S;
  typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_e;
endpackage

// File: rtl/rx_fifo_ram.sv
// rx_fifo_ram: simple dual-port storage with registered read data.
module rx_fifo_ram #(
  parameter int W     = mac_if_pkg::D,
  parameter int DEPTH = mac_if_pkg::DEPTH,
  parameter int A     = mac_if_pkg::D_S
) (
  input  logic         clk,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: store-and-forward AXIS receive buffer that drops bad or oversize frames.
// Define RX_FRAME_FIFO_STATS_EN to build the saturating drop_count counter.
module rx_frame_fifo #(
  parameter int N     = mac_if_pkg::N,
  parameter int S     = mac_if_pkg::S,
  parameter int D     = N + S + 1,
  parameter int DEPTH = mac_if_pkg::DEPTH,
  parameter int D_S   = mac_if_pkg::D_S
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] rx_axis_tdata,
  input  logic [S-1:0] rx_axis_tkeep,
  input  logic         rx_axis_tvalid,
  input  logic         rx_axis_tlast,
  input  logic         rx_axis_tuser,
  output logic [D-1:0] write_pipe_data,
  output logic         write_pipe_req,
  input  logic         write_pipe_ack,
  output logic [15:0]  drop_count
);
  import mac_if_pkg::*;
  localparam int P = D_S + 1;
  state_e state_q, state_d;
  logic [P-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, fp_q, fp_d;
  logic [D-1:0] ram_rdata, data_q, data_d;
  logic full, we, re, load, ram_vld_q, ram_vld_d, req_q, req_d, xfer;
  assign full = (wr_q - rd_q) == P'(DEPTH);
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cm_d    = cm_q;
    we      = 1'b0;
    if (rx_axis_tvalid) begin
      if (state_q == SYNC || state_q == DROP) begin
        state_d = rx_axis_tlast ? IDLE : state_q;
      end else if (full || (rx_axis_tlast && rx_axis_tuser)) begin
        wr_d    = cm_q;
        state_d = rx_axis_tlast ? IDLE : DROP;
      end else begin
        we      = 1'b1;
        wr_d    = wr_q + P'(1);
        cm_d    = rx_axis_tlast ? wr_q + P'(1) : cm_q;
        state_d = rx_axis_tlast ? IDLE : RECV;
      end
    end
  end
  // rd_q frees a slot only once the consumer takes the word; fp_q is the RAM fetch address
  assign xfer      = req_q && write_pipe_ack;
  assign load      = ram_vld_q && (!req_q || write_pipe_ack);
  assign re        = (cm_q != fp_q) && (!ram_vld_q || load);
  assign fp_d      = re ? fp_q + P'(1) : fp_q;
  assign rd_d      = xfer ? rd_q + P'(1) : rd_q;
  assign ram_vld_d = re || (ram_vld_q && !load);
  assign req_d     = load || (req_q && !write_pipe_ack);
  assign data_d    = load ? ram_rdata : data_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SYNC;
      wr_q      <= '0;
      cm_q      <= '0;
      rd_q      <= '0;
      fp_q      <= '0;
      ram_vld_q <= 1'b0;
      req_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      cm_q      <= cm_d;
      rd_q      <= rd_d;
      fp_q      <= fp_d;
      ram_vld_q <= ram_vld_d;
      req_q     <= req_d;
      data_q    <= data_d;
    end
  end
  rx_fifo_ram #(.W(D), .DEPTH(DEPTH), .A(D_S)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_q[D_S-1:0]),
    .wdata ({rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata}),
    .re    (re),
    .raddr (fp_q[D_S-1:0]),
    .rdata (ram_rdata)
  );
  assign write_pipe_req  = req_q;
  assign write_pipe_data = data_q;
`ifdef RX_FRAME_FIFO_STATS_EN
  logic drop;
  logic [15:0] cnt_q;
  assign drop = rx_axis_tvalid && (state_q == IDLE || state_q == RECV) &&
                (full || (rx_axis_tlast && rx_axis_tuser));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else if (drop && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign drop_count = cnt_q;
`else
  assign drop_count = 16'h0;
`endif
endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo: directed scenario bench for rx_frame_fifo.
module tb_rx_frame_fifo;
  localparam int N = 32, S = 4, D = 37;
`ifdef RX_FRAME_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] tdata = '0;
  logic [S-1:0] tkeep = '0;
  logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, ack = 1'b0;
  logic [D-1:0] pdata;
  logic preq;
  logic [15:0] dc;
  int compared = 0, mismatched = 0, exp_drop = 0, cyc = 0;
  logic [D-1:0] got[$];
  int got_cyc[$];

  rx_frame_fifo dut (
    .clk(clk), .reset(reset), .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep),
    .rx_axis_tvalid(tvalid), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .write_pipe_data(pdata), .write_pipe_req(preq), .write_pipe_ack(ack),
    .drop_count(dc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (preq && ack) begin
    got.push_back(pdata);
    got_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tuser = u;
    tick();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    compared++; if (preq !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b expected 0", preq); end
    compared++; if (pdata !== '0) begin mismatched++; $display("FAIL reset_data: got %h expected 0", pdata); end
    compared++; if (dc !== 16'h0) begin mismatched++; $display("FAIL reset_drop: got %h expected 0", dc); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_sync_latency();
    ack = 1'b1;
    got.delete(); got_cyc.delete();
    beat(32'd1, 4'hF, 1'b0, 1'b0);
    beat(32'd500, 4'hF, 1'b0, 1'b0);
    beat(32'd4000, 4'hF, 1'b1, 1'b0);
    idle(2);
    beat(32'd7, 4'hF, 1'b0, 1'b0);
    beat(32'd8, 4'hF, 1'b1, 1'b0);
    compared++; if (preq !== 1'b0) begin mismatched++; $display("FAIL lat_e0_req: got %b expected 0", preq); end
    tick();
    compared++; if (preq !== 1'b0) begin mismatched++; $display("FAIL lat_e1_req: got %b expected 0", preq); end
    tick();
    compared++; if ({preq, pdata} !== {1'b1, 1'b0, 4'hF, 32'd7}) begin mismatched++; $display("FAIL lat_e2_word: got %b/%h expected 1/%h", preq, pdata, {1'b0, 4'hF, 32'd7}); end
    tick();
    compared++; if ({preq, pdata} !== {1'b1, 1'b1, 4'hF, 32'd8}) begin mismatched++; $display("FAIL lat_e3_word: got %b/%h expected 1/%h", preq, pdata, {1'b1, 4'hF, 32'd8}); end
    tick();
    compared++; if (preq !== 1'b0) begin mismatched++; $display("FAIL lat_e4_req: got %b expected 0", preq); end
    compared++; if (got.size() !== 2) begin mismatched++; $display("FAIL sync_count: got %0d expected 2", got.size()); end
    compared++; if (dc !== 16'h0) begin mismatched++; $display("FAIL sync_drop: got %h expected 0", dc); end
  endtask

  task automatic test_bad_frame();
    got.delete(); got_cyc.delete();
    beat(32'd10, 4'hF, 1'b0, 1'b0);
    beat(32'd11, 4'hF, 1'b0, 1'b0);
    beat(32'd12, 4'hF, 1'b0, 1'b0);
    beat(32'd13, 4'hF, 1'b1, 1'b1);
    exp_drop++;
    idle(6);
    compared++; if (got.size() !== 0) begin mismatched++; $display("FAIL bad_none: got %0d words expected 0", got.size()); end
    compared++; if (dc !== (STATS ? 16'(exp_drop) : 16'h0)) begin mismatched++; $display("FAIL bad_drop: got %0d expected %0d", dc, STATS ? exp_drop : 0); end
    beat(32'd20, 4'hF, 1'b0, 1'b0);
    beat(32'd21, 4'hF, 1'b1, 1'b0);
    idle(6);
    compared++; if (got.size() !== 2) begin mismatched++; $display("FAIL bad_next_count: got %0d expected 2", got.size()); end
    else begin
      compared++; if (got[0] !== {1'b0, 4'hF, 32'd20}) begin mismatched++; $display("FAIL bad_next_w0: got %h expected %h", got[0], {1'b0, 4'hF, 32'd20}); end
      compared++; if (got[1] !== {1'b1, 4'hF, 32'd21}) begin mismatched++; $display("FAIL bad_next_w1: got %h expected %h", got[1], {1'b1, 4'hF, 32'd21}); end
    end
  endtask

  task automatic test_full();
    logic [D-1:0] exp;
    ack = 1'b0;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 128; i++) beat(32'(1000 + i), 4'hF, (i % 32) == 31, 1'b0);
    idle(5);
    compared++; if ({preq, pdata} !== {1'b1, 1'b0, 4'hF, 32'd1000}) begin mismatched++; $display("FAIL full_head: got %b/%h expected 1/%h", preq, pdata, {1'b0, 4'hF, 32'd1000}); end
    for (int i = 0; i < 5; i++) beat(32'(5000 + i), 4'hF, i == 4, 1'b0);
    exp_drop++;
    idle(5);
    compared++; if (dc !== (STATS ? 16'(exp_drop) : 16'h0)) begin mismatched++; $display("FAIL full_drop: got %0d expected %0d", dc, STATS ? exp_drop : 0); end
    compared++; if (pdata !== {1'b0, 4'hF, 32'd1000}) begin mismatched++; $display("FAIL full_hold: got %h expected %h", pdata, {1'b0, 4'hF, 32'd1000}); end
    ack = 1'b1;
    idle(135);
    compared++; if (got.size() !== 128) begin mismatched++; $display("FAIL full_count: got %0d expected 128", got.size()); end
    else begin
      for (int i = 0; i < 128; i++) begin
        exp = {(i % 32) == 31, 4'hF, 32'(1000 + i)};
        compared++; if (got[i] !== exp) begin mismatched++; $display("FAIL full_word%0d: got %h expected %h", i, got[i], exp); end
      end
      compared++; if (got_cyc[127] - got_cyc[0] !== 127) begin mismatched++; $display("FAIL full_rate: got %0d cycles expected 127", got_cyc[127] - got_cyc[0]); end
    end
  endtask

  task automatic test_long_frame();
    ack = 1'b1;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 200; i++) beat(32'(3000 + i), 4'hF, i == 199, 1'b0);
    exp_drop++;
    idle(6);
    compared++; if (got.size() !== 0) begin mismatched++; $display("FAIL long_none: got %0d words expected 0", got.size()); end
    compared++; if (dc !== (STATS ? 16'(exp_drop) : 16'h0)) begin mismatched++; $display("FAIL long_drop: got %0d expected %0d", dc, STATS ? exp_drop : 0); end
    beat(32'd40, 4'hF, 1'b0, 1'b0);
    beat(32'd41, 4'hF, 1'b1, 1'b0);
    idle(6);
    compared++; if (got.size() !== 2) begin mismatched++; $display("FAIL long_next_count: got %0d expected 2", got.size()); end
    else begin
      compared++; if (got[0] !== {1'b0, 4'hF, 32'd40}) begin mismatched++; $display("FAIL long_next_w0: got %h expected %h", got[0], {1'b0, 4'hF, 32'd40}); end
      compared++; if (got[1] !== {1'b1, 4'hF, 32'd41}) begin mismatched++; $display("FAIL long_next_w1: got %h expected %h", got[1], {1'b1, 4'hF, 32'd41}); end
    end
  endtask

  task automatic test_single_beat();
    got.delete(); got_cyc.delete();
    beat(32'hDEADBEEF, 4'b0011, 1'b1, 1'b0);
    idle(6);
    compared++; if (got.size() !== 1) begin mismatched++; $display("FAIL single_count: got %0d expected 1", got.size()); end
    else begin
      compared++; if (got[0] !== {1'b1, 4'b0011, 32'hDEADBEEF}) begin mismatched++; $display("FAIL single_word: got %h expected %h", got[0], {1'b1, 4'b0011, 32'hDEADBEEF}); end
    end
  endtask

  task automatic test_reset_mid_drain();
    ack = 1'b0;
    got.delete(); got_cyc.delete();
    beat(32'd50, 4'hF, 1'b0, 1'b0);
    beat(32'd51, 4'hF, 1'b0, 1'b0);
    beat(32'd52, 4'hF, 1'b1, 1'b0);
    idle(4);
    compared++; if (preq !== 1'b1) begin mismatched++; $display("FAIL rst_pre_req: got %b expected 1", preq); end
    #2 reset = 1'b1;
    #1;
    compared++; if (preq !== 1'b0) begin mismatched++; $display("FAIL rst_async_req: got %b expected 0", preq); end
    compared++; if (pdata !== '0) begin mismatched++; $display("FAIL rst_async_data: got %h expected 0", pdata); end
    compared++; if (dc !== 16'h0) begin mismatched++; $display("FAIL rst_async_drop: got %h expected 0", dc); end
    compared++; if ({dut.wr_q, dut.cm_q, dut.rd_q} !== '0) begin mismatched++; $display("FAIL rst_ptrs: got %h/%h/%h expected 0/0/0", dut.wr_q, dut.cm_q, dut.rd_q); end
    tick();
    reset = 1'b0;
    exp_drop = 0;
    ack = 1'b1;
    beat(32'd60, 4'hF, 1'b0, 1'b0);
    beat(32'd61, 4'hF, 1'b1, 1'b0);
    beat(32'd70, 4'hF, 1'b0, 1'b0);
    beat(32'd71, 4'hF, 1'b1, 1'b0);
    idle(8);
    compared++; if (got.size() !== 2) begin mismatched++; $display("FAIL rst_after_count: got %0d expected 2", got.size()); end
    else begin
      compared++; if (got[0] !== {1'b0, 4'hF, 32'd70}) begin mismatched++; $display("FAIL rst_after_w0: got %h expected %h", got[0], {1'b0, 4'hF, 32'd70}); end
      compared++; if (got[1] !== {1'b1, 4'hF, 32'd71}) begin mismatched++; $display("FAIL rst_after_w1: got %h expected %h", got[1], {1'b1, 4'hF, 32'd71}); end
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_bad_frame();
    test_full();
    test_long_frame();
    test_single_beat();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rx_frame_fifo.md
RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 Parameter N, default 32: AXIS data width in bits.
REQ-002 Parameter S, default 4: tkeep width (N/8).
REQ-003 Parameter D, default N+S+1 (37): pipe word width.
REQ-004 Parameter DEPTH, default 128: buffer depth in words; D_S, default 7, is log2(DEPTH).
REQ-005 Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-high.
- rx_axis_tdata  in  N: MAC receive data.
- rx_axis_tkeep  in  S: byte enables.
- rx_axis_tvalid  in  1: beat valid.
- rx_axis_tlast  in  1: last beat of frame.
- rx_axis_tuser  in  1: bad-frame flag, meaningful only with tlast.
- write_pipe_data  out  D: {last, keep[S-1:0], data[N-1:0]}, last at bit D-1.
- write_pipe_req  out  1: write_pipe_data valid.
- write_pipe_ack  in  1: consumer accepts the word.
- drop_count  out  16: dropped-frame counter.

Function
REQ-006 No backpressure to the MAC; every beat with tvalid=1 is sampled.
REQ-007 Store-and-forward: no word of a frame is presented on the pipe until its tlast beat has been committed.
REQ-008 Buffer state: wr_ptr (speculative), commit_ptr and rd_ptr, each D_S+1 bits, wrapping modulo 2*DEPTH.
REQ-009 Full when wr_ptr-rd_ptr==DEPTH, computed from registered pointers; a same-cycle read frees a slot only from the next cycle.
REQ-010 FSM states SYNC, IDLE, RECV, DROP.
- SYNC: reset state; beats are discarded; a tlast beat moves to IDLE.
- IDLE: a valid non-last beat is written and moves to RECV.
- RECV: valid beats are written.
- DROP: beats are discarded until tlast, then move to IDLE.
REQ-011 Good tlast (tuser=0, buffer not full): the beat is written and commit_ptr<=wr_ptr+1 on the same edge; the FSM moves to IDLE. A single-beat frame commits directly from IDLE.
REQ-012 Bad tlast (tuser=1): the beat is not written, wr_ptr<=commit_ptr, drop_count increments, and the FSM moves to IDLE.
REQ-013 Valid beat while full:
- Beat not written; wr_ptr<=commit_ptr.
- The FSM moves to DROP, or to IDLE if that beat carries tlast.
- drop_count increments once per frame.
REQ-014 A frame longer than DEPTH words is always dropped per REQ-013.
REQ-015 Output register holds the head word; write_pipe_req=1 while it is valid and is independent of write_pipe_ack.
REQ-016 A transfer occurs when req&&ack on a rising edge; the register reloads in the same edge if more committed data exists.
REQ-017 Sustained throughput is one word per clk while ack is held high.
REQ-018 Latency: the first word of a committed frame reaches write_pipe_req=1 exactly 2 clk edges after the commit edge, provided the output register was empty.
REQ-019 write_pipe_data is held stable while req=1 and ack=0.
REQ-020 Words beyond commit_ptr are never presented.
REQ-021 tkeep and tlast pass through unmodified.

Reset
REQ-022 Asynchronous reset drives:
- all pointers to 0; FSM to SYNC;
- write_pipe_req to 0; write_pipe_data to 0; drop_count to 0.
REQ-023 Reset asserted mid-frame or mid-drain discards all buffered and partial data; the first frame accepted afterwards is the one following the next tlast.

Configuration
REQ-024 Macro RX_FRAME_FIFO_STATS_EN defined: drop_count counts dropped frames and saturates at 16'hFFFF.
REQ-025 Macro RX_FRAME_FIFO_STATS_EN undefined: drop_count is tied to 0 and no counter logic is built.

Structure
REQ-026 Package mac_if_pkg holds N, S, D, DEPTH, D_S, the field positions of the pipe word, and the FSM state encoding.
REQ-027 Storage is a separate sub-module rx_fifo_ram: simple dual-port, DEPTH x D, synchronous read, one write port and one read port.

Verification
REQ-028 After reset, a 3-beat frame with tuser=0 and data 1, 500, 4000 is dropped because the FSM is in SYNC. The next frame, data 7, 8 with tlast on 8, produces pipe words {0,F,7} and {1,F,8} with ack=1, and the first req=1 occurs 2 clk after the tlast edge.
REQ-029 A 4-beat frame ends with tlast and tuser=1 -> no pipe output; drop_count=1 (with macro); the next good frame is output intact.
REQ-030 ack=0 while 128 words of committed frames are buffered, then a 5-beat frame arrives -> the 5-beat frame is dropped and drop_count increments. After ack=1, all 128 earlier words drain in order, one per clk.
REQ-031 A 200-beat frame with ack=1 -> dropped; no pipe word is emitted for it.
REQ-032 Reset is pulsed mid-drain with req=1 -> req=0 asynchronously, pointers are 0, and no stale word appears afterwards.
REQ-033 A single-beat frame with keep=4'b0011 and data 0xDEADBEEF -> exactly one pipe word, {1, 4'b0011, 32'hDEADBEEF}.
